// File: rtl/minibus_arbiter.sv
// Round-robin arbiter sharing one Mini-Bus slave port between NUM_MASTERS
// requesters. One transaction at a time: IDLE picks a master, BUSY forwards
// its request and routes the slave response back, RECOVER inserts one dead
// cycle so a registered slave ack can never be reused by the next grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; round-robin search for the next pending master
// BUSY    | granted master forwarded to slave; waiting for ack/err/timeout
// RECOVER | slave port quiet for one cycle, counter cleared, back to IDLE
//
// ADDR_WIDTH/DATA_WIDTH default to the Mini-Bus package widths (32/32).

module minibus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic [NUM_MASTERS-1:0]            m_wen,
    input  logic [NUM_MASTERS-1:0]            m_ren,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS*2-1:0]          m_width,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_wen,
    output logic                              s_ren,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic [1:0]                        s_width,
    output logic                              s_sel,
    input  logic                              s_ack,
    input  logic                              s_err,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
    output logic                              busy
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] pending;
    logic                   pick_valid;
    logic [GW-1:0]          pick_idx;

    logic                   g_wen;
    logic                   g_ren;
    logic [ADDR_WIDTH-1:0]  g_addr;
    logic [DATA_WIDTH-1:0]  g_wdata;
    logic [1:0]             g_width;

    logic                   resp_ack;
    logic                   resp_err;

    // Select the live request fields of the currently granted master.
    always_comb begin
        g_wen   = 1'b0;
        g_ren   = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_width = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == GW'(i)) begin
                g_wen   = m_wen[i];
                g_ren   = m_ren[i];
                g_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_width = m_width[i*2 +: 2];
            end
        end
    end

    // Round-robin search starting just after the last served master.
    always_comb begin
        pending    = m_wen | m_ren;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!pick_valid && pending[i] &&
                    ((int'(last_q) + k) % NUM_MASTERS) == i) begin
                    pick_valid = 1'b1;
                    pick_idx   = GW'(i);
                end
            end
        end
    end

    // Next-state logic and all bus-facing outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        s_wen    = 1'b0;
        s_ren    = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_width  = '0;
        s_sel    = 1'b0;
        m_rdata  = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (cnt_q == '0 && g_wen && g_ren) begin
                    // Read+write together is rejected without touching the slave.
                    resp_err = 1'b1;
                    state_d  = ST_RECOVER;
                end else if (!g_wen && !g_ren) begin
                    // Master withdrew: abandon quietly, no response.
                    state_d = ST_RECOVER;
                end else begin
                    s_sel   = 1'b1;
                    s_wen   = g_wen;
                    s_ren   = g_ren;
                    s_addr  = g_addr;
                    s_wdata = g_wdata;
                    s_width = g_width;
                    if (s_err) begin
                        resp_err = 1'b1;
                        state_d  = ST_RECOVER;
                    end else if (s_ack) begin
                        resp_ack = 1'b1;
                        m_rdata  = s_rdata;
                        state_d  = ST_RECOVER;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        resp_err = 1'b1;
                        state_d  = ST_RECOVER;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_RECOVER: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Steer the single completion pulse to the granted master only.
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == GW'(i)) begin
                m_ack[i] = resp_ack;
                m_err[i] = resp_err;
            end
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        grant_id = grant_q;
        busy     = (state_q != ST_IDLE);
    end

    // State, grant, round-robin pointer and timeout counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
